// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the local ejector: flit type encoding, widths,
// destination field positions and ejector state encoding.
package noc_flit_pkg;

  localparam int unsigned FLIT_W = 34;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned DEST_X_MSB = 31;
  localparam int unsigned DEST_X_LSB = 28;
  localparam int unsigned DEST_Y_MSB = 27;
  localparam int unsigned DEST_Y_LSB = 24;

  typedef enum logic [1:0] {
    PAYLOAD = 2'b00,
    HEADER  = 2'b01,
    LAST    = 2'b10,
    SINGLE  = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_DROP
  } ej_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } eject_word_t;

  localparam int unsigned WORD_W = $bits(eject_word_t);

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered storage, count-based full/empty flags and
// synchronous active-high reset that also clears the storage.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_local_ejector.sv
// Receive-side endpoint of the router local port: framing check FSM, output FIFO,
// packet/error counters. Optional destination check enabled by EJECT_DEST_CHECK_EN.
module noc_local_ejector
  import noc_flit_pkg::*;
#(
  parameter int unsigned FLIT_W = 34,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XADDR  = 0,
  parameter int unsigned YADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] local_out_flit_i,
  input  logic              local_out_valid_i,
  output logic              local_out_ready_o,
  output logic [31:0]       core_data_o,
  output logic              core_sop_o,
  output logic              core_eop_o,
  output logic              core_err_o,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  output logic [15:0]       pkt_count_o,
  output logic [7:0]        err_count_o
);

`ifdef EJECT_DEST_CHECK_EN
  localparam bit DEST_CHECK = 1'b1;
`else
  localparam bit DEST_CHECK = 1'b0;
`endif

  localparam logic [3:0] LOCAL_X = 4'(XADDR);
  localparam logic [3:0] LOCAL_Y = 4'(YADDR);

  ej_state_t         state_q, state_d;
  flit_type_t        ftype;
  logic [DATA_W-1:0] fdata;
  logic              take;
  logic              misroute;
  logic              push;
  logic              err_inc;
  logic              full;
  logic              empty;
  logic              pop;
  eject_word_t       wr_word;
  eject_word_t       rd_word;

  assign ftype    = flit_type_t'(local_out_flit_i[FLIT_W-1 -: 2]);
  assign fdata    = local_out_flit_i[DATA_W-1:0];
  assign take     = local_out_valid_i && local_out_ready_o;
  assign misroute = DEST_CHECK &&
                    ((fdata[DEST_X_MSB:DEST_X_LSB] != LOCAL_X) ||
                     (fdata[DEST_Y_MSB:DEST_Y_LSB] != LOCAL_Y));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A misrouted start flit aborts any open packet with a single error count.
  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    err_inc      = 1'b0;
    wr_word      = '0;
    wr_word.data = fdata;
    if (take) begin
      unique case (ftype)
        HEADER, SINGLE: begin
          if (misroute) begin
            err_inc = 1'b1;
            state_d = (ftype == HEADER) ? ST_DROP : ST_IDLE;
          end else begin
            push        = 1'b1;
            wr_word.sop = 1'b1;
            wr_word.eop = (ftype == SINGLE);
            wr_word.err = (state_q == ST_BODY);
            err_inc     = (state_q == ST_BODY);
            state_d     = (ftype == HEADER) ? ST_BODY : ST_IDLE;
          end
        end
        PAYLOAD, LAST: begin
          unique case (state_q)
            ST_BODY: begin
              push        = 1'b1;
              wr_word.eop = (ftype == LAST);
              if (ftype == LAST) state_d = ST_IDLE;
            end
            ST_DROP: begin
              if (ftype == LAST) state_d = ST_IDLE;
            end
            default: err_inc = 1'b1;
          endcase
        end
      endcase
    end
  end

  noc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_word),
    .full  (full),
    .pop   (pop),
    .dout  (rd_word),
    .empty (empty)
  );

  assign local_out_ready_o = !full;
  assign core_valid_o      = !empty;
  assign pop               = core_valid_o && core_ready_i;
  assign core_data_o       = rd_word.data;
  assign core_sop_o        = rd_word.sop;
  assign core_eop_o        = rd_word.eop;
  assign core_err_o        = rd_word.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_o <= '0;
      err_count_o <= '0;
    end else begin
      if (pop && rd_word.eop) begin
        pkt_count_o <= pkt_count_o + 16'd1;
      end
      if (err_inc && (err_count_o != '1)) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

endmodule
